instr_injector: RTL and testbench
=================================

INSTR_INJECTOR -- requirements
Module: instr_injector

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Parameter NOP_INST, default 32'h00000013, SHALL be the instruction word driven whenever no injected word is issuing.
REQ-003 Parameter DRAIN_CYCLES, default 5, SHALL be the number of NOP cycles issued after each injected word so it leaves writeback.
REQ-004 Parameter TIMEOUT_CYCLES, default 1023, SHALL be the maximum idle cycles allowed between bytes of one word.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 rx_data  input  8  received instruction byte from the UART receiver.
REQ-008 rx_valid  input  1  rx_data holds a valid byte this cycle.
REQ-009 rx_ready  output  1  the block accepts a byte this cycle.
REQ-010 inst_addr  input  32  fetch address from the CPU; it is unused internally and kept for port symmetry.
REQ-011 inst_out  output  32  instruction word presented to the CPU fetch stage.
REQ-012 busy  output  1  an injected word is issuing or draining.
REQ-013 done  output  1  one-cycle pulse when the drain completes.
REQ-014 timeout_err  output  1  one-cycle pulse when a partial word is discarded.

Function
REQ-015 The FSM SHALL have exactly four states: COLLECT, ISSUE, DRAIN and DONE.
REQ-016 In COLLECT, rx_ready SHALL be 1; a byte SHALL be accepted only when rx_valid and rx_ready are both 1.
REQ-017 Bytes SHALL assemble little-endian: byte 0 goes to bits 7:0 and byte 3 goes to bits 31:24.
REQ-018 A 2-bit byte counter SHALL count accepted bytes; on the 4th byte it SHALL wrap to 0 and the FSM SHALL go to ISSUE on the next edge.
REQ-019 In ISSUE, inst_out SHALL equal the assembled word for exactly one cycle, starting the cycle after the 4th byte is accepted; the next state SHALL be DRAIN.
REQ-020 In every state other than ISSUE, inst_out SHALL equal NOP_INST.
REQ-021 DRAIN SHALL last exactly DRAIN_CYCLES cycles, counted by a down-counter loaded on entry, and then go to DONE.
REQ-022 DONE SHALL last one cycle, assert done, and then return to COLLECT.
REQ-023 rx_ready SHALL be 0 in ISSUE, DRAIN and DONE; bytes offered in those states SHALL be neither stored nor dropped, since the sender holds them.
REQ-024 busy SHALL be 1 in ISSUE and DRAIN and 0 in COLLECT and DONE.
REQ-025 In COLLECT with the byte count nonzero, an idle counter SHALL increment on each cycle with no byte accepted and SHALL clear on each accepted byte.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES, the byte count and the assembled word SHALL clear and timeout_err SHALL pulse for one cycle.
REQ-027 If a byte is accepted in the same cycle the timeout is reached, the byte SHALL win: it is stored and no timeout occurs.
REQ-028 The idle counter SHALL stay at 0 while the byte count is 0; no timeout SHALL occur between words.

Reset
REQ-029 Reset SHALL force all of the following: state COLLECT, byte count 0, assembled word 0, idle and drain counters 0, inst_out NOP_INST, rx_ready 1, busy 0, done 0, timeout_err 0.
REQ-030 Reset asserted mid-word or mid-drain SHALL discard all progress, with no done or timeout_err pulse.

Structure
REQ-031 The default NOP encoding and the FSM state encoding SHALL live in the shared CPU package and be used by this block and the testbench.
REQ-032 The byte-assembly and timeout logic SHALL be one sub-module, byte_assembler, which outputs a word_valid pulse; the top SHALL contain the FSM and the drain counter.

Verification
REQ-033 Bytes 93,00,50,00 on consecutive cycles -> inst_out = 32'h00500093 for exactly one cycle, then 5 NOP cycles, then done pulses.
REQ-034 Bytes offered continuously during DRAIN -> rx_ready = 0 throughout, and the next word is accepted only after done.
REQ-035 Two bytes, then an idle gap of 1023 cycles -> timeout_err pulses; the next 4 bytes assemble a correct fresh word.
REQ-036 A byte lands exactly on the timeout cycle -> it is stored, with no timeout_err.
REQ-037 Reset asserted in DRAIN cycle 3 -> the next cycle shows COLLECT state, inst_out = NOP_INST, and done never pulses.
REQ-038 Two back-to-back words -> two ISSUE cycles separated by at least DRAIN_CYCLES+1 cycles, each showing its correct word.

Source files
------------

// File: rtl/instr_injector_pkg.sv
// Shared CPU definitions: default NOP encoding, injector FSM state codes,
// and a byte-lane insert helper used by the byte assembler.
package instr_injector_pkg;

    // ADDI x0, x0, 0 -- the canonical RISC-V NOP.
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef logic [1:0] state_t;

    localparam state_t ST_COLLECT = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_DRAIN   = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    // Write byte b into lane idx of word (lane 0 = bits 7:0, little-endian).
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] w_res;
        w_res = word;
        w_res[{idx, 3'b000} +: 8] = b;
        return w_res;
    endfunction

endpackage

// File: rtl/instr_injector_byte_assembler.sv
// Assembles four received bytes into a little-endian instruction word and
// discards a partial word if the sender goes quiet for too long.
module byte_assembler
    import instr_injector_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_timeout_err
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    // Idle value at which the next empty cycle would reach the limit.
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    r_count;
    logic [31:0]   r_word;
    logic [IW-1:0] r_idle;
    logic          r_timeout_err;
    logic          w_timeout;

    // An accepted byte on the limit cycle wins, so the timeout needs !i_accept.
    assign w_timeout = (r_count != 2'd0) && !i_accept && (r_idle == IDLE_LAST);

    // Byte storage, byte counter, idle counter and timeout pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_count       <= 2'd0;
            r_word        <= 32'd0;
            r_idle        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            if (i_accept) begin
                r_word  <= insert_byte(r_word, r_count, i_data);
                r_count <= r_count + 2'd1;
                r_idle  <= '0;
            end else if (w_timeout) begin
                r_count       <= 2'd0;
                r_word        <= 32'd0;
                r_idle        <= '0;
                r_timeout_err <= 1'b1;
            end else if (r_count != 2'd0) begin
                r_idle <= r_idle + IW'(1);
            end else begin
                r_idle <= '0;
            end
        end
    end

    // The 4th byte completes the word; the FSM moves to ISSUE on this edge.
    assign o_word_valid  = i_accept && (r_count == 2'd3);
    assign o_word        = r_word;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: rtl/instr_injector.sv
// Injects UART-received instruction words into the CPU fetch stream: one
// cycle of the word, then NOPs until it has left writeback.
module instr_injector
    import instr_injector_pkg::*;
#(
    parameter logic [31:0] NOP_INST       = NOP_INST_DEFAULT,
    parameter int          DRAIN_CYCLES   = 5,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_out,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t        r_state;
    logic [DW-1:0] r_drain;
    logic          w_accept;
    logic          w_word_valid;
    logic [31:0]   w_word;
    logic          w_unused_addr;

    // Fetch address is kept only for port symmetry with the CPU.
    assign w_unused_addr = ^inst_addr;

    // Bytes are taken only while collecting; otherwise the sender holds them.
    assign w_accept = rx_valid && rx_ready;

    byte_assembler #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_byte_assembler (
        .clk           (clk),
        .reset         (reset),
        .i_accept      (w_accept),
        .i_data        (rx_data),
        .o_word        (w_word),
        .o_word_valid  (w_word_valid),
        .o_timeout_err (timeout_err)
    );

    // Sequencer: collect -> issue one word -> drain NOPs -> done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_COLLECT;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_word_valid) r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_state <= ST_DRAIN;
                    r_drain <= DW'(DRAIN_CYCLES);
                end
                ST_DRAIN: begin
                    if (r_drain == DW'(1)) begin
                        r_state <= ST_DONE;
                        r_drain <= '0;
                    end else begin
                        r_drain <= r_drain - DW'(1);
                    end
                end
                ST_DONE: r_state <= ST_COLLECT;
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        // NOTE: every output gets a value on every path, so no latch forms.
        inst_out = NOP_INST;
        if (r_state == ST_ISSUE) inst_out = w_word;
        rx_ready = (r_state == ST_COLLECT);
        busy     = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
        done     = (r_state == ST_DONE);
    end

endmodule

// File: tb/tb_instr_injector.sv
// Directed bench for instr_injector: expected words go into a scoreboard
// queue as they are sent and are popped when the DUT enters ISSUE.
module tb_instr_injector;
    import instr_injector_pkg::*;

    localparam int DRAIN = 5;
    localparam int TOUT  = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] inst_addr;
    logic [31:0] inst_out;
    logic        busy;
    logic        done;
    logic        timeout_err;

    always #5 clk = ~clk;

    instr_injector #(
        .NOP_INST       (NOP_INST_DEFAULT),
        .DRAIN_CYCLES   (DRAIN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .inst_addr   (inst_addr),
        .inst_out    (inst_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    int          n_assert      = 0;
    int          n_fail        = 0;
    int          cyc           = 0;
    int          done_cnt      = 0;
    int          tout_cnt      = 0;
    int          last_done_cyc = -1;
    int          acc_cyc       = 0;
    int          first_acc_cyc = 0;
    bit          prev_busy     = 1'b0;
    logic [31:0] exp_q[$];
    int          issue_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle scoreboard and output invariants.
    task automatic monitor();
        logic issuing;
        issuing = busy && !prev_busy;
        if (issuing) begin
            issue_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("issue_unexpected", inst_out, NOP_INST_DEFAULT ^ 32'h1);
            else                   chk("issue_word", inst_out, exp_q.pop_front());
        end else begin
            chk("nop_out", inst_out, NOP_INST_DEFAULT);
        end
        chk("rx_ready_rel", 32'(rx_ready), 32'(!(busy || done)));
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (timeout_err) tout_cnt++;
        prev_busy = busy;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc      = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = rx_ready;
            if (acc) acc_cyc = cyc;
            step();
        end
        if (!acc) chk("send_byte_stall", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] w_tmp;
        w_tmp = w;
        exp_q.push_back(w_tmp);
        for (int k = 0; k < 4; k++) begin
            send_byte(w_tmp[8*k +: 8]);
            if (k == 0) first_acc_cyc = acc_cyc;
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gap;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        inst_addr = 32'h8000_0000;

        // Reset state
        steps(2);
        chk("rst_inst_out", inst_out, NOP_INST_DEFAULT);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        step();

        // Single word: one ISSUE cycle, DRAIN NOPs, then done
        send_word(32'h0050_0093);
        chk("w1_busy_issue", 32'(busy), 32'd1);
        for (int i = 0; i < DRAIN; i++) begin
            step();
            chk("w1_busy_drain", 32'(busy), 32'd1);
            chk("w1_done_drain", 32'(done), 32'd0);
        end
        step();
        chk("w1_done", 32'(done), 32'd1);
        chk("w1_busy_done", 32'(busy), 32'd0);
        step();
        chk("w1_done_clear", 32'(done), 32'd0);
        chk("w1_ready_back", 32'(rx_ready), 32'd1);

        // Back-to-back words with bytes held during drain
        inst_addr = 32'h8000_0004;
        send_word(32'hA1B2_C3D4);
        send_word(32'h1357_9BDF);
        gap = issue_cyc[issue_cyc.size()-1] - issue_cyc[issue_cyc.size()-2];
        chk("b2b_issue_gap", 32'(gap), 32'(DRAIN + 6));
        chk("b2b_accept_after_done", 32'(first_acc_cyc), 32'(last_done_cyc + 1));
        steps(DRAIN + 2);

        // No timeout between words
        base = tout_cnt;
        steps(TOUT + 80);
        chk("idle_between_words", 32'(tout_cnt - base), 32'd0);

        // Partial word then 1023 idle cycles
        base = tout_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        rx_valid = 1'b0;
        steps(TOUT - 1);
        chk("to_not_early", 32'(timeout_err), 32'd0);
        step();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        step();
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        chk("to_count", 32'(tout_cnt - base), 32'd1);
        send_word(32'h1234_5678);
        steps(DRAIN + 2);

        // Byte arriving exactly on the timeout cycle wins
        base = tout_cnt;
        exp_q.push_back(32'h0050_0093);
        send_byte(8'h93);
        send_byte(8'h00);
        rx_valid = 1'b0;
        steps(TOUT - 1);
        send_byte(8'h50);
        send_byte(8'h00);
        rx_valid = 1'b0;
        chk("edge_issue_busy", 32'(busy), 32'd1);
        steps(DRAIN + 3);
        chk("edge_no_timeout", 32'(tout_cnt - base), 32'd0);

        // Reset in DRAIN cycle 3
        base = done_cnt;
        send_word(32'h0040_A023);
        steps(3);
        chk("rst_drain_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        chk("rst_drain_ready", 32'(rx_ready), 32'd1);
        chk("rst_drain_busy0", 32'(busy), 32'd0);
        chk("rst_drain_inst", inst_out, NOP_INST_DEFAULT);
        chk("rst_drain_done", 32'(done), 32'd0);
        reset = 1'b0;
        steps(DRAIN + 3);
        chk("rst_drain_no_done", 32'(done_cnt - base), 32'd0);

        // Recovery after reset
        send_word(32'hFEDC_BA98);
        steps(DRAIN + 3);
        chk("recover_done", 32'(done_cnt - base), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
